// File: rtl/fp32_pkg.sv
// Shared constants and FSM state type for the binary32 divider.
package fp32_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    ROUND,
    DONE
  } state_t;
endpackage

// File: rtl/fp32_classify.sv
// Splits a binary32 word into fields and flags its class; exponent 0 counts as zero.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       i_val,
  output logic              o_sign,
  output logic [7:0]        o_exp,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_is_zero,
  output logic              o_is_inf,
  output logic              o_is_nan
);
  assign o_sign    = i_val[31];
  assign o_exp     = i_val[30:FRAC_W];
  assign o_frac    = i_val[FRAC_W-1:0];
  assign o_is_zero = (o_exp == 8'd0);
  assign o_is_inf  = (o_exp == 8'hFF) && (o_frac == '0);
  assign o_is_nan  = (o_exp == 8'hFF) && (o_frac != '0);
endmodule

// File: rtl/fp32_div.sv
// Sequential binary32 divider: restoring division, one quotient bit per cycle,
// round-to-nearest-even, fixed 30-cycle latency for every operand class.
module fp32_div
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);
  state_t r_state, w_state_next;

  logic [31:0]       r_a, r_b;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [23:0]       r_m2;
  logic [24:0]       r_rem;
  logic [26:0]       r_q;
  logic [4:0]        r_cnt;
  logic              r_nan, r_inf, r_zero;

  logic [31:0]       w_op   [2];
  logic              w_sign [2];
  logic [7:0]        w_exp  [2];
  logic [FRAC_W-1:0] w_frac_in [2];
  logic              w_zero [2];
  logic              w_inf  [2];
  logic              w_nan  [2];

  assign w_op[0] = r_a;
  assign w_op[1] = r_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
      fp32_classify u_cls (
        .i_val     (w_op[gi]),
        .o_sign    (w_sign[gi]),
        .o_exp     (w_exp[gi]),
        .o_frac    (w_frac_in[gi]),
        .o_is_zero (w_zero[gi]),
        .o_is_inf  (w_inf[gi]),
        .o_is_nan  (w_nan[gi])
      );
    end
  endgenerate

  // Restoring step: remainder stays below 2*divisor, so it fits in 25 bits.
  logic        w_ge;
  logic [24:0] w_rem_sel;
  assign w_ge      = (r_rem >= {1'b0, r_m2});
  assign w_rem_sel = w_ge ? (r_rem - {1'b0, r_m2}) : r_rem;

  // Quotient lies in [2^25, 2^27), so the hidden bit is always Q[26] or Q[25].
  logic              w_norm, w_guard, w_sticky, w_inc;
  logic [22:0]       w_frac;
  logic [23:0]       w_frac_r;
  logic signed [9:0] w_exp_n, w_exp_r;
  logic [31:0]       w_result;

  assign w_norm   = r_q[26];
  assign w_frac   = w_norm ? r_q[25:3] : r_q[24:2];
  assign w_guard  = w_norm ? r_q[2] : r_q[1];
  assign w_sticky = (w_norm ? (|r_q[1:0]) : r_q[0]) | (|r_rem);
  assign w_exp_n  = w_norm ? r_exp : (r_exp - 10'sd1);
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_r = {1'b0, w_frac} + {23'd0, w_inc};
  assign w_exp_r  = w_frac_r[23] ? (w_exp_n + 10'sd1) : w_exp_n;

  always_comb begin
    w_result = {r_sign, w_exp_r[7:0], w_frac_r[22:0]};
    if (r_nan)
      w_result = QNAN;
    else if (r_inf)
      w_result = {r_sign, POS_INF[30:0]};
    else if (r_zero)
      w_result = {r_sign, 31'd0};
    else if (w_exp_r >= $signed(10'(EXP_MAX)))
      w_result = {r_sign, POS_INF[30:0]};
    else if (w_exp_r <= 10'sd0)
      w_result = {r_sign, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE:   if (start) w_state_next = UNPACK;
      UNPACK: begin
        busy         = 1'b1;
        w_state_next = DIVIDE;
      end
      DIVIDE: begin
        busy = 1'b1;
        if (r_cnt == 5'd0) w_state_next = ROUND;
      end
      ROUND: begin
        busy         = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_m2   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_nan  <= 1'b0;
      r_inf  <= 1'b0;
      r_zero <= 1'b0;
      out    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a <= in1;
            r_b <= in2;
          end
        end
        UNPACK: begin
          r_sign <= w_sign[0] ^ w_sign[1];
          r_exp  <= {2'b00, w_exp[0]} - {2'b00, w_exp[1]} + 10'(EXP_BIAS);
          r_rem  <= {2'b01, w_frac_in[0]};
          r_m2   <= {1'b1, w_frac_in[1]};
          r_q    <= '0;
          r_cnt  <= 5'd26;
          r_nan  <= w_nan[0] | w_nan[1] | (w_inf[0] & w_inf[1]) | (w_zero[0] & w_zero[1]);
          r_inf  <= w_inf[0] | w_zero[1];
          r_zero <= w_zero[0] | w_inf[1];
        end
        DIVIDE: begin
          r_q   <= {r_q[25:0], w_ge};
          r_rem <= w_rem_sel << 1;
          r_cnt <= r_cnt - 5'd1;
        end
        ROUND: out <= w_result;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_div.sv
// Directed bench for fp32_div: result values, latency, pulse width, ignored starts, reset abort.
module tb_fp32_div;
  logic        clk, rst_n, start;
  logic [31:0] in1, in2, out;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  fp32_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation from IDLE and watches a 40-cycle window; cycle 1 is the
  // cycle after the sampling edge. Optionally re-pulses start at cycle intr_c.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int intr_c,
                       output logic [31:0] res, output int lat, output int pulses,
                       output logic busy1, output logic busy_done);
    res = 32'hDEADBEEF; lat = -1; pulses = 0; busy1 = 1'b0; busy_done = 1'b1;
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) busy1 = busy;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = c; res = out; busy_done = busy;
        end
      end
      if (c == intr_c) begin
        start = 1'b1; in1 = 32'h3F800000; in2 = 32'h40400000;
      end else if (c == intr_c + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("op %h / %h -> %h lat=%0d pulses=%0d", a, b, res, lat, pulses);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [31:0] res; int lat, pulses; logic b1, bd;
    do_op(32'h40C00000, 32'h40000000, -10, res, lat, pulses, b1, bd);
    total++; if (res !== 32'h40400000) begin bad++; $display("FAIL basic_val got=%h exp=%h", res, 32'h40400000); end
    total++; if (lat !== 30) begin bad++; $display("FAIL basic_latency got=%0d exp=30", lat); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy_c1 got=%b exp=1", b1); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b exp=0", bd); end
    total++; if (out !== 32'h40400000) begin bad++; $display("FAIL basic_hold got=%h exp=%h", out, 32'h40400000); end
  endtask

  task automatic test_rounding();
    logic [31:0] va [4] = '{32'h3F800000, 32'hC0E00000, 32'h3F800000, 32'hC0C00000};
    logic [31:0] vb [4] = '{32'h40400000, 32'h40600000, 32'hC0400000, 32'hC0000000};
    logic [31:0] ve [4] = '{32'h3EAAAAAB, 32'hC0000000, 32'hBEAAAAAB, 32'h40400000};
    logic [31:0] res; int lat, pulses; logic b1, bd;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], -10, res, lat, pulses, b1, bd);
      total++; if (res !== ve[i]) begin bad++; $display("FAIL round_val[%0d] got=%h exp=%h", i, res, ve[i]); end
      total++; if (lat !== 30) begin bad++; $display("FAIL round_latency[%0d] got=%0d exp=30", i, lat); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [7] = '{32'h7F800000, 32'h40000000, 32'h00000000, 32'h447C7333,
                            32'hBF800000, 32'h00000000, 32'h40000000};
    logic [31:0] vb [7] = '{32'hFF800000, 32'h00000000, 32'h00000000, 32'hFF800001,
                            32'h00000000, 32'hC0000000, 32'h7F800000};
    logic [31:0] ve [7] = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                            32'hFF800000, 32'h80000000, 32'h00000000};
    logic [31:0] res; int lat, pulses; logic b1, bd;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], -10, res, lat, pulses, b1, bd);
      total++; if (res !== ve[i]) begin bad++; $display("FAIL special_val[%0d] got=%h exp=%h", i, res, ve[i]); end
      total++; if (lat !== 30) begin bad++; $display("FAIL special_latency[%0d] got=%0d exp=30", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] va [3] = '{32'h7F7FFFFF, 32'h00800000, 32'h00000001};
    logic [31:0] vb [3] = '{32'h3F000000, 32'h40000000, 32'h3F800000};
    logic [31:0] ve [3] = '{32'h7F800000, 32'h00000000, 32'h00000000};
    logic [31:0] res; int lat, pulses; logic b1, bd;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], -10, res, lat, pulses, b1, bd);
      total++; if (res !== ve[i]) begin bad++; $display("FAIL range_val[%0d] got=%h exp=%h", i, res, ve[i]); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res; int lat, pulses; logic b1, bd;
    do_op(32'h40C00000, 32'h40000000, 10, res, lat, pulses, b1, bd);
    total++; if (res !== 32'h40400000) begin bad++; $display("FAIL ignore_busy_val got=%h exp=%h", res, 32'h40400000); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL ignore_busy_pulses got=%0d exp=1", pulses); end
    do_op(32'hC0E00000, 32'h40600000, 30, res, lat, pulses, b1, bd);
    total++; if (res !== 32'hC0000000) begin bad++; $display("FAIL ignore_done_val got=%h exp=%h", res, 32'hC0000000); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL ignore_done_pulses got=%0d exp=1", pulses); end
    total++; if (out !== 32'hC0000000) begin bad++; $display("FAIL ignore_done_hold got=%h exp=%h", out, 32'hC0000000); end
  endtask

  task automatic test_reset_abort();
    int lat = -1;
    int pulses = 0;
    logic [31:0] res = 32'hDEADBEEF;
    logic [31:0] out_c29 = 32'hDEADBEEF;
    in1 = 32'h3F800000; in2 = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (out !== 32'h0) begin bad++; $display("FAIL abort_out got=%h exp=%h", out, 32'h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    rst_n = 1'b1;
    in1 = 32'h40C00000; in2 = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 29) out_c29 = out;
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = c; res = out; end
      end
      @(posedge clk); #1;
    end
    $display("op after abort %h / %h -> %h lat=%0d pulses=%0d", 32'h40C00000, 32'h40000000, res, lat, pulses);
    total++; if (out_c29 !== 32'h0) begin bad++; $display("FAIL abort_out_held got=%h exp=%h", out_c29, 32'h0); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", pulses); end
    total++; if (lat !== 30) begin bad++; $display("FAIL abort_restart_latency got=%0d exp=30", lat); end
    total++; if (res !== 32'h40400000) begin bad++; $display("FAIL abort_restart_val got=%h exp=%h", res, 32'h40400000); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_range();
    test_ignore_start();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
